uart_txrx: RTL and testbench
============================

# uart_txrx

8N1 UART serial engine sitting directly below the UART bus register block: it consumes the one-cycle `start` strobe and byte `tx_data` from the register block and serialises them onto `tx`. It deserialises `rx` into `rx_data` with a one-cycle `rx_done` strobe that sets the register block's RX-valid flag. Timing comes from a 16x-oversampled baud tick derived from the system clock.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency in Hz
- `BAUD`, 9600, line rate in bit/s
- `OVS`, 16, oversampling ticks per bit (fixed at 16; not overridden)

- `clk`  in  1  system clock; reset is `reset`, asynchronous, active-high, and the clock is `clk`
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle transmit request
- `tx_data`  in  8  byte to send, sampled on an accepted `start`
- `tx_done`  out  1  one-cycle pulse, frame fully sent
- `tx_busy`  out  1  high while a frame is in flight
- `tx`  out  1  serial output, idle high
- `rx`  in  1  asynchronous serial input
- `rx_data`  out  8  last correctly framed byte
- `rx_done`  out  1  one-cycle pulse, `rx_data` updated

## Operation
- DIV = CLK_HZ / (BAUD*16), integer-truncated; 100 MHz / 9600 gives 651. One bit = 16 ticks = 16*DIV cycles.
- **Frame:** start bit 0, then 8 data bits LSB first, then 1 stop bit.
- **TX FSM:** IDLE -> START -> DATA -> STOP -> IDLE.
  - `start` is accepted only when `tx_busy`=0. It latches `tx_data`, clears the TX tick divider, and enters START.
  - `start` while busy is ignored; no queueing.
  - Each state holds for 16 ticks. DATA holds 8 bits, tracked by a 3-bit counter that wraps 7 -> 0 on exit.
- **RX front end:** 2-FF synchroniser on `rx`. All RX logic uses the synchronised value.
- **RX FSM:** IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a low level clears the RX divider and enters START.
  - START: at tick 7 (mid-bit), if the line is still low, go to DATA. Otherwise it is a glitch: return to IDLE with no output.
  - DATA: sample every 16 ticks from mid-start (mid-bit of each data bit) and shift right into the MSB, giving LSB-first assembly.
  - STOP: sample at mid-stop.
    - High: load `rx_data`, pulse `rx_done`, go to IDLE.
    - Low (framing error): discard the byte, no `rx_done`, `rx_data` unchanged; go to IDLE, which waits for the line high before re-arming.
- TX and RX are fully independent; simultaneous activity is allowed.
- **Reset values:** `tx`=1, `tx_busy`=0, `tx_done`=0, `rx_data`=8'h00, `rx_done`=0, both FSMs in IDLE, dividers 0. Reset mid-frame aborts immediately: `tx` returns high asynchronously, and a partial RX byte is lost.

## Timing
- **TX start latency:** `start` at edge N gives `tx`=0 and `tx_busy`=1 after edge N (registered output, 1 cycle).
- **TX frame length:** exactly 160*DIV cycles from `tx` falling to `tx_busy` falling.
- **TX end of frame:** `tx_done`=1 for one cycle, coincident with `tx_busy` falling.
  - A `start` in that same cycle is accepted.
  - Back-to-back frames therefore have no idle gap beyond the stop bit.
- **RX detection:** `rx_done` and the new `rx_data` appear together, registered, 2 sync cycles + 1 cycle after the mid-stop sample.
  - This is about 9.5 bit-times after the line's falling edge.
  - `rx_data` holds until the next good frame.
- **RX back-to-back:** RX re-arms at mid-stop, so a following start bit arriving right after the stop bit is caught. Tolerates at least ±3% baud mismatch.
- Tick divider counts 0..DIV-1 and pulses `tick` on DIV-1. A clear forces the count to 0.

## Structure
- Package `uart_pkg`:
  - TX/RX state encodings (2-bit: IDLE=0, START=1, DATA=2, STOP=3)
  - `OVS`=16 and a `DIV` calc function
  - `MID_TICK`=7
- Sub-module `uart_baud_gen` (parameter DIV; ports `clk`, `reset`, `clr`, `tick`), instantiated twice: once for TX, once for RX.
- `uart_txrx` holds the synchroniser, TX FSM/shift register, and RX FSM/shift register.

## Test plan
Bench parameters: CLK_HZ=1_600_000, BAUD=100_000, giving DIV=1 and a 16-cycle bit.
- **TX single byte:** `start` with `tx_data`=8'hA5 -> `tx` shows 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. `tx_done` pulses at cycle 160 after `tx` falls, with `tx_busy` falling in the same cycle.
- **TX start while busy:** `start` with 8'h3C at cycle 50 of an 8'hA5 frame -> ignored; only 8'hA5 appears on `tx` and only one `tx_done`.
- **TX back-to-back:** `start` with 8'h01 held in the `tx_done` cycle -> a second frame begins on the next cycle, with no extra idle bits.
- **RX good frame:** drive 8'h5A, 8N1 at 16 cycles/bit -> one `rx_done` pulse and `rx_data`=8'h5A. Then loop `tx` to `rx` with 8'hFF then 8'h00 sent back-to-back -> two `rx_done` pulses, reading 8'hFF then 8'h00.
- **RX glitch and framing error:**
  - A 4-cycle low glitch on `rx` -> no `rx_done`.
  - A frame with stop bit 0 carrying 8'h77 -> no `rx_done`, and `rx_data` keeps its previous value 8'h5A.
- **Reset mid-frame:** assert `reset` at cycle 80 of a TX frame and of an RX frame -> `tx`=1, `tx_busy`=0, `rx_data`=0 immediately. The next full frames then transmit and receive correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the 8N1 UART engine.
//   uart_state_t : 2-bit state encoding used by both the TX and RX FSMs
//   OVS          : oversampling ticks per bit
//   MID_TICK     : tick index inside the start bit treated as mid-bit
//   calc_div     : system clocks per oversampling tick, truncated
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int OVS      = 16;
    localparam int MID_TICK = 7;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OVS);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversampling tick generator.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   clr   : synchronous clear, forces the count back to 0
//   tick  : high while the count sits on DIV-1 (one cycle in every DIV)
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int              CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   TOP = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || (cnt == TOP)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // With DIV=1 the count never leaves 0, so tick is permanently high.
    assign tick = (cnt == TOP);

endmodule

// File: rtl/uart_txrx.sv
// uart_txrx: 8N1 UART transmitter and receiver with 16x oversampling.
//   clk, reset : system clock, asynchronous active-high reset
//   start      : one-cycle transmit request, accepted only when not busy
//   tx_data    : byte captured on an accepted start
//   tx_done    : one-cycle pulse when the stop bit has fully gone out
//   tx_busy    : high from the accepted start until the end of the stop bit
//   tx         : serial output, idle high
//   rx         : asynchronous serial input
//   rx_data    : last byte received with a valid stop bit
//   rx_done    : one-cycle pulse, rx_data updated in the same cycle
module uart_txrx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600,
    parameter int OVS    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx_busy,
    output logic       tx,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done
);

    import uart_pkg::*;

    localparam int         DIV       = calc_div(CLK_HZ, BAUD);
    localparam logic [3:0] LAST_TICK = 4'(OVS - 1);
    localparam logic [3:0] MID       = 4'(MID_TICK);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_state_t tx_state;
    logic [3:0]  tx_tick_cnt;
    logic [2:0]  tx_bit_cnt;
    logic [7:0]  tx_shift;
    logic        tx_tick;
    logic        tx_clr;

    // Restart the divider on an accepted start so the start bit is a full bit.
    assign tx_clr = start && (tx_state == ST_IDLE);

    uart_baud_gen #(.DIV(DIV)) u_tx_baud (
        .clk   (clk),
        .reset (reset),
        .clr   (tx_clr),
        .tick  (tx_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state    <= ST_IDLE;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_shift    <= '0;
            tx          <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (tx_state)
                ST_IDLE: begin
                    if (start) begin
                        tx_shift    <= tx_data;
                        tx_tick_cnt <= '0;
                        tx_bit_cnt  <= '0;
                        tx          <= 1'b0;
                        tx_busy     <= 1'b1;
                        tx_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_tick) begin
                        if (tx_tick_cnt == LAST_TICK) begin
                            tx_tick_cnt <= '0;
                            tx          <= tx_shift[0];
                            tx_state    <= ST_DATA;
                        end else begin
                            tx_tick_cnt <= tx_tick_cnt + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tx_tick) begin
                        if (tx_tick_cnt == LAST_TICK) begin
                            tx_tick_cnt <= '0;
                            tx_bit_cnt  <= tx_bit_cnt + 3'd1;   // wraps 7 -> 0
                            if (tx_bit_cnt == 3'd7) begin
                                tx       <= 1'b1;
                                tx_state <= ST_STOP;
                            end else begin
                                // Bit 0 of the shifter is always the bit on the line.
                                tx       <= tx_shift[1];
                                tx_shift <= {1'b0, tx_shift[7:1]};
                            end
                        end else begin
                            tx_tick_cnt <= tx_tick_cnt + 4'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tx_tick) begin
                        if (tx_tick_cnt == LAST_TICK) begin
                            tx_tick_cnt <= '0;
                            tx_busy     <= 1'b0;
                            tx_done     <= 1'b1;
                            tx_state    <= ST_IDLE;
                        end else begin
                            tx_tick_cnt <= tx_tick_cnt + 4'd1;
                        end
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver input synchroniser (resets to the idle-high line level)
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    uart_state_t rx_state;
    logic [3:0]  rx_tick_cnt;
    logic [2:0]  rx_bit_cnt;
    logic [7:0]  rx_shift;
    logic        rx_armed;
    logic        rx_tick;
    logic        rx_clr;

    // rx_armed drops after a framing error (line still low) and comes back
    // only once the line has been seen high, so a stuck-low line or a
    // long break cannot be mistaken for a stream of start bits.
    assign rx_clr = (rx_state == ST_IDLE) && rx_armed && !rx_sync;

    uart_baud_gen #(.DIV(DIV)) u_rx_baud (
        .clk   (clk),
        .reset (reset),
        .clr   (rx_clr),
        .tick  (rx_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state    <= ST_IDLE;
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_shift    <= '0;
            rx_armed    <= 1'b0;
            rx_data     <= 8'h00;
            rx_done     <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (rx_state)
                ST_IDLE: begin
                    if (!rx_armed) begin
                        rx_armed <= rx_sync;
                    end else if (!rx_sync) begin
                        rx_tick_cnt <= '0;
                        rx_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_tick) begin
                        if (rx_tick_cnt == MID) begin
                            // From here on every 16th tick lands mid-bit.
                            rx_tick_cnt <= '0;
                            rx_bit_cnt  <= '0;
                            rx_state    <= rx_sync ? ST_IDLE : ST_DATA;
                        end else begin
                            rx_tick_cnt <= rx_tick_cnt + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_tick) begin
                        if (rx_tick_cnt == LAST_TICK) begin
                            rx_tick_cnt <= '0;
                            rx_shift    <= {rx_sync, rx_shift[7:1]};
                            rx_bit_cnt  <= rx_bit_cnt + 3'd1;
                            if (rx_bit_cnt == 3'd7) begin
                                rx_state <= ST_STOP;
                            end
                        end else begin
                            rx_tick_cnt <= rx_tick_cnt + 4'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (rx_tick) begin
                        if (rx_tick_cnt == LAST_TICK) begin
                            rx_tick_cnt <= '0;
                            if (rx_sync) begin
                                rx_data <= rx_shift;
                                rx_done <= 1'b1;
                            end else begin
                                rx_armed <= 1'b0;
                            end
                            // Leaving at mid-stop leaves half a bit of margin
                            // to catch a start bit that follows immediately.
                            rx_state <= ST_IDLE;
                        end else begin
                            rx_tick_cnt <= rx_tick_cnt + 4'd1;
                        end
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_txrx.sv
// tb_uart_txrx: self-checking bench for uart_txrx at DIV=1 (16 cycles per bit).
// The reference model describes a frame as ten line levels (start, eight data
// bits LSB first, stop) and a received-byte queue of frames with a high stop bit.
module tb_uart_txrx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       tx_busy;
    logic       tx;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_done;

    logic       rx_drv  = 1'b1;
    logic       loop_en = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rx_got[$];
    logic [7:0] rx_exp[$];

    always #5 clk = ~clk;

    assign rx_line = loop_en ? tx : rx_drv;

    uart_txrx #(
        .CLK_HZ (1_600_000),
        .BAUD   (100_000),
        .OVS    (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .tx_data (tx_data),
        .tx_done (tx_done),
        .tx_busy (tx_busy),
        .tx      (tx),
        .rx      (rx_line),
        .rx_data (rx_data),
        .rx_done (rx_done)
    );

    // Collect every cycle rx_done is high; a stretched pulse shows up as extra entries.
    always @(negedge clk) begin
        if (rx_done === 1'b1) rx_got.push_back(rx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level of bit slot idx of an 8N1 frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int idx, input logic stop_lvl);
        if (idx == 0) return 1'b0;
        if (idx == 9) return stop_lvl;
        return d[idx-1];
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called one negedge after start was raised. Checks the whole frame on tx,
    // optionally pokes a start at cycle poke_at, optionally chains a start in
    // the tx_done cycle.
    task automatic monitor_tx(input logic [7:0] d, input int poke_at, input logic [7:0] poke_d,
                              input logic chain, input logic [7:0] chain_d);
        int dones = 0;
        for (int m = 0; m <= 160; m++) begin
            @(negedge clk);
            if (m == 0) start = 1'b0;
            if (m == poke_at + 1) start = 1'b0;
            if (m < 160 && tx_done === 1'b1) dones++;
            if (m == 0) check("tx_busy_rise", {31'd0, tx_busy}, 32'd1);
            if (m < 160)
                check($sformatf("tx_line_%02h_m%0d", d, m), {31'd0, tx},
                      {31'd0, frame_bit(d, m / 16, 1'b1)});
            if (m == 159) check("tx_busy_last_cycle", {31'd0, tx_busy}, 32'd1);
            if (m == 160) begin
                check("tx_done_pulse", {31'd0, tx_done}, 32'd1);
                check("tx_busy_fall", {31'd0, tx_busy}, 32'd0);
                check("tx_idle_high", {31'd0, tx}, 32'd1);
                check("tx_no_early_done", dones, 32'd0);
            end
            if (m == poke_at) begin
                start   = 1'b1;
                tx_data = poke_d;
            end
            if (m == 160 && chain) begin
                start   = 1'b1;
                tx_data = chain_d;
            end
        end
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic stop_lvl);
        for (int b = 0; b < 10; b++) begin
            rx_drv = frame_bit(d, b, stop_lvl);
            repeat (16) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_count"}, rx_got.size(), rx_exp.size());
        while (rx_got.size() > 0 && rx_exp.size() > 0)
            check({tag, "_data"}, {24'd0, rx_got.pop_front()}, {24'd0, rx_exp.pop_front()});
        rx_got.delete();
        rx_exp.delete();
    endtask

    initial begin
        logic [7:0] d;
        reset   = 1'b1;
        start   = 1'b0;
        tx_data = 8'h00;
        wait_cycles(3);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_tx_done", {31'd0, tx_done}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'h00);
        check("rst_rx_done", {31'd0, rx_done}, 32'd0);
        reset = 1'b0;
        wait_cycles(20);

        // Single TX frame
        start = 1'b1; tx_data = 8'hA5;
        monitor_tx(8'hA5, -10, 8'h00, 1'b0, 8'h00);
        wait_cycles(5);

        // Start while busy must be dropped, not queued
        start = 1'b1; tx_data = 8'hA5;
        monitor_tx(8'hA5, 50, 8'h3C, 1'b0, 8'h00);
        wait_cycles(20);
        check("tx_busy_ignored_start", {31'd0, tx_busy}, 32'd0);
        check("tx_line_ignored_start", {31'd0, tx}, 32'd1);

        // Back-to-back: start in the tx_done cycle
        start = 1'b1; tx_data = 8'hA5;
        monitor_tx(8'hA5, -10, 8'h00, 1'b1, 8'h01);
        monitor_tx(8'h01, -10, 8'h00, 1'b0, 8'h00);
        wait_cycles(5);

        // Random TX bytes
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            start = 1'b1; tx_data = d;
            monitor_tx(d, -10, 8'h00, 1'b0, 8'h00);
            wait_cycles(3);
        end

        // RX good frame
        drive_rx(8'h5A, 1'b1);
        rx_exp.push_back(8'h5A);
        wait_cycles(30);
        check_rx("rx_5a");
        check("rx_data_5a", {24'd0, rx_data}, 32'h5A);

        // Short glitch: no byte
        rx_drv = 1'b0;
        wait_cycles(4);
        rx_drv = 1'b1;
        wait_cycles(40);
        check_rx("rx_glitch");

        // Framing error: no byte, rx_data held
        drive_rx(8'h77, 1'b0);
        wait_cycles(40);
        check_rx("rx_framing");
        check("rx_data_hold_5a", {24'd0, rx_data}, 32'h5A);

        // Loopback, back-to-back FF then 00
        loop_en = 1'b1;
        wait_cycles(2);
        start = 1'b1; tx_data = 8'hFF;
        monitor_tx(8'hFF, -10, 8'h00, 1'b1, 8'h00);
        monitor_tx(8'h00, -10, 8'h00, 1'b0, 8'h00);
        rx_exp.push_back(8'hFF);
        rx_exp.push_back(8'h00);
        wait_cycles(30);
        check_rx("rx_loop");
        loop_en = 1'b0;
        wait_cycles(5);

        // Random RX bytes, back-to-back, then a known non-zero byte
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            drive_rx(d, 1'b1);
            rx_exp.push_back(d);
        end
        drive_rx(8'hC3, 1'b1);
        rx_exp.push_back(8'hC3);
        wait_cycles(30);
        check_rx("rx_rand");
        check("rx_data_c3", {24'd0, rx_data}, 32'hC3);

        // Reset 80 cycles into a TX frame
        start = 1'b1; tx_data = 8'h00;
        @(negedge clk);
        start = 1'b0;
        wait_cycles(79);
        reset = 1'b1;
        #1;
        check("rst_mid_tx", {31'd0, tx}, 32'd1);
        check("rst_mid_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_mid_rx_data", {24'd0, rx_data}, 32'h00);
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(10);

        // Reset 80 cycles into an RX frame
        for (int c = 0; c < 80; c++) begin
            rx_drv = frame_bit(8'h96, c / 16, 1'b1);
            @(negedge clk);
        end
        reset = 1'b1;
        rx_drv = 1'b1;
        #1;
        check("rst_mid_rx_data2", {24'd0, rx_data}, 32'h00);
        check("rst_mid_rx_done", {31'd0, rx_done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(120);
        check_rx("rx_aborted");

        // Full frames after reset: loopback a random byte, then drive one
        loop_en = 1'b1;
        wait_cycles(2);
        d = 8'($urandom);
        start = 1'b1; tx_data = d;
        monitor_tx(d, -10, 8'h00, 1'b0, 8'h00);
        rx_exp.push_back(d);
        wait_cycles(30);
        check_rx("rx_post_reset_loop");
        loop_en = 1'b0;
        wait_cycles(5);
        d = 8'($urandom);
        drive_rx(d, 1'b1);
        rx_exp.push_back(d);
        wait_cycles(30);
        check_rx("rx_post_reset_drive");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
